// File: rtl/snn_debug_readout.sv
// Debug readout serializer: snapshots both layers' membrane potentials and spikes
// on capture, then streams a framed byte packet (A5, seq, neuron bytes, xor csum).
module snn_debug_readout #(
  parameter  int N1 = 8,
  parameter  int N2 = 8,
  localparam int PW = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic [(N1+N2)*PW-1:0] membrane_potential_in,
  input  logic [N1-1:0]         spikes_layer1,
  input  logic [N2-1:0]         spikes_layer2,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clear_overrun
);
  localparam int N  = N1 + N2;
  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {IDLE, HEADER, SEQ, DATA, CSUM} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, nxt_idx;
  logic [7:0]          seq_q, seq_d, csum_q, csum_d;
  logic [N*PW-1:0]     pot_q;
  logic [N-1:0]        spk_q;
  logic [N-1:0][7:0]   nb;
  logic [7:0]          data_d;
  logic                valid_d, last_d, overrun_d, snap_en, hs;

  // Neuron byte layout: {spike, 0, potential}
  for (genvar i = 0; i < N; i++) begin : g_nb
    assign nb[i] = {spk_q[i], 1'b0, pot_q[i*PW +: PW]};
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    csum_d    = csum_q;
    data_d    = out_data;
    valid_d   = out_valid;
    last_d    = out_last;
    snap_en   = 1'b0;
    hs        = out_valid && out_ready;
    nxt_idx   = (state_q == SEQ) ? '0 : idx_q + 1'b1;
    overrun_d = overrun;
    if (capture && state_q != IDLE) overrun_d = 1'b1;
    else if (clear_overrun)         overrun_d = 1'b0;

    case (state_q)
      IDLE: if (capture) begin
        snap_en = 1'b1;
        csum_d  = '0;
        state_d = HEADER;
        data_d  = 8'hA5;
        valid_d = 1'b1;
        last_d  = 1'b0;
      end
      HEADER: if (hs) begin
        csum_d  = csum_q ^ out_data;
        state_d = SEQ;
        data_d  = seq_q;
      end
      SEQ: if (hs) begin
        csum_d  = csum_q ^ out_data;
        state_d = DATA;
        idx_d   = '0;
        data_d  = nb[nxt_idx];
      end
      DATA: if (hs) begin
        csum_d = csum_q ^ out_data;
        if (idx_q == IW'(N-1)) begin
          state_d = CSUM;
          data_d  = csum_q ^ out_data;
          last_d  = 1'b1;
        end else begin
          idx_d  = nxt_idx;
          data_d = nb[nxt_idx];
        end
      end
      CSUM: if (hs) begin
        seq_d   = seq_q + 8'd1;
        state_d = IDLE;
        data_d  = 8'h00;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      seq_q     <= '0;
      csum_q    <= '0;
      pot_q     <= '0;
      spk_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      csum_q    <= csum_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= (state_d != IDLE);
      overrun   <= overrun_d;
      if (snap_en) begin
        pot_q <= membrane_potential_in;
        spk_q <= {spikes_layer2, spikes_layer1};
      end
    end
  end
endmodule

// File: tb/tb_snn_debug_readout.sv
// Bench for snn_debug_readout: table-driven frames checked through a byte scoreboard,
// plus backpressure, overrun, sequence-wrap and mid-frame reset sequences.
module tb_snn_debug_readout;
  localparam int N1 = 8, N2 = 8, N = N1 + N2, NB = N + 3;

  logic           clk = 1'b0, reset = 1'b1, capture = 1'b0, out_ready = 1'b1, clear_overrun = 1'b0;
  logic [N*6-1:0] membrane_potential_in = '0;
  logic [N1-1:0]  spikes_layer1 = '0;
  logic [N2-1:0]  spikes_layer2 = '0;
  logic [7:0]     out_data;
  logic           out_valid, out_last, busy, overrun;

  snn_debug_readout #(.N1(N1), .N2(N2)) dut (
    .clk(clk), .reset(reset), .capture(capture),
    .membrane_potential_in(membrane_potential_in),
    .spikes_layer1(spikes_layer1), .spikes_layer2(spikes_layer2),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*6-1:0] pot;
    logic [N1-1:0]  s1;
    logic [N2-1:0]  s2;
    logic [7:0]     dxor;  // XOR of the neuron bytes alone
  } vec_t;

  int         tests = 0, fails = 0;
  logic [7:0] exp_seq = 8'd0;
  logic [8:0] exp_q[$];    // {last, data}
  logic [7:0] got_csum, got_seq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame built straight from the byte format
  task automatic push_frame(input logic [N*6-1:0] pot, input logic [N1-1:0] s1, input logic [N2-1:0] s2);
    logic [7:0] b, cs;
    logic [N-1:0] spk;
    spk = {s2, s1};
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, exp_seq});
    cs = 8'hA5 ^ exp_seq;
    for (int i = 0; i < N; i++) begin
      b = {spk[i], 1'b0, pot[i*6 +: 6]};
      cs ^= b;
      exp_q.push_back({1'b0, b});
    end
    exp_q.push_back({1'b1, cs});
    exp_seq = exp_seq + 8'd1;
  endtask

  // Drain one frame; stall 3 cycles on bytes st0/st1, capture (with clear) when bytes cp0/cp1 are accepted
  task automatic collect(input int st0, input int st1, input int cp0, input int cp1);
    int b = 0, stall = 0, cyc = 0;
    bit stalled = 0;
    logic [9:0] held, cur;
    logic [8:0] e;
    while (b < NB && cyc < 200) begin
      @(negedge clk);
      cyc++;
      capture = 1'b0; clear_overrun = 1'b0;
      if (cyc == 1) begin
        membrane_potential_in = {$urandom, $urandom, $urandom};
        spikes_layer1 = 8'($urandom); spikes_layer2 = 8'($urandom);
      end
      cur = {out_valid, out_last, out_data};
      if (stall == 0 && !stalled && (b == st0 || b == st1)) begin
        stall = 3; stalled = 1; held = cur;
      end else if (stall > 0) check("stall_hold", 32'(cur), 32'(held));
      if (stall > 0) begin
        out_ready = 1'b0; stall--;
      end else begin
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
          check("queue_underflow", 32'd1, 32'd0); e = '0;
        end else e = exp_q.pop_front();
        check($sformatf("byte%0d", b), 32'(cur), 32'({1'b1, e}));
        if (b == 1) got_seq = out_data;
        if (b == NB-1) got_csum = out_data;
        if (b == cp0 || b == cp1) begin capture = 1'b1; clear_overrun = 1'b1; end
        b++; stalled = 0;
      end
    end
    if (b < NB) check("frame_timeout", 32'(b), 32'(NB));
    @(negedge clk);
    capture = 1'b0; clear_overrun = 1'b0; out_ready = 1'b1;
    check("post_frame_vlb", 32'({out_valid, out_last, busy}), 32'd0);
  endtask

  task automatic run_frame(input logic [N*6-1:0] pot, input logic [N1-1:0] s1, input logic [N2-1:0] s2,
                           input int st0, input int st1, input int cp0, input int cp1);
    membrane_potential_in = pot; spikes_layer1 = s1; spikes_layer2 = s2;
    push_frame(pot, s1, s2);
    @(negedge clk); capture = 1'b1;
    collect(st0, st1, cp0, cp1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; capture = 1'b0;
    @(negedge clk); reset = 1'b0;
    exp_seq = 8'd0; exp_q.delete();
  endtask

  vec_t vecs[4];
  logic [N*6-1:0] p;

  initial begin
    p = '0; p[5:0] = 6'h3F; p[15*6 +: 6] = 6'h01;
    vecs[0] = '{'0, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{p, 8'h01, 8'h00, 8'hBE};
    for (int i = 0; i < N; i++) p[i*6 +: 6] = 6'(i);
    vecs[2] = '{p, 8'h5A, 8'h01, 8'h80};
    vecs[3] = '{'1, 8'hFF, 8'hFF, 8'h00};

    do_reset();
    check("reset_outputs", 32'({out_data, out_valid, out_last, busy, overrun}), 32'd0);

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].pot, vecs[v].s1, vecs[v].s2, -1, -1, -1, -1);
      check($sformatf("csum_vec%0d", v), 32'(got_csum), 32'(8'hA5 ^ 8'(v) ^ vecs[v].dxor));
    end

    // Stalls on SEQ and CSUM
    do_reset();
    run_frame(vecs[1].pot, vecs[1].s1, vecs[1].s2, 1, NB-1, -1, -1);
    check("bp_csum", 32'(got_csum), 32'h1B);

    // Dropped captures mid-frame and on the CSUM handshake (clear in same cycle)
    do_reset();
    run_frame(vecs[2].pot, vecs[2].s1, vecs[2].s2, -1, -1, 4, NB-1);
    check("overrun_set", 32'(overrun), 32'd1);
    @(negedge clk); clear_overrun = 1'b1;
    @(negedge clk); clear_overrun = 1'b0;
    check("overrun_clear", 32'(overrun), 32'd0);
    run_frame(vecs[0].pot, vecs[0].s1, vecs[0].s2, -1, -1, -1, -1);
    check("seq_after_overrun", 32'(got_seq), 32'h01);

    // Sequence wrap
    do_reset();
    for (int f = 0; f < 257; f++) run_frame('0, '0, '0, -1, -1, -1, -1);
    check("seq_wrap", 32'(got_seq), 32'h00);

    // Reset mid-frame
    run_frame('0, '0, '0, -1, -1, -1, -1);
    @(negedge clk); capture = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); capture = 1'b0; end
    check("midframe_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midframe_reset", 32'({out_data, out_valid, out_last, busy, overrun}), 32'd0);
    exp_seq = 8'd0; exp_q.delete();
    run_frame(vecs[1].pot, vecs[1].s1, vecs[1].s2, -1, -1, -1, -1);
    check("post_reset_seq", 32'(got_seq), 32'h00);
    check("post_reset_csum", 32'(got_csum), 32'h1B);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
